// File: rtl/dec3f.sv
// Three-phase sequence decoder: synchronises the A/B/C phase lines, decodes the
// 6-step sector and reports direction, lock, faults and the electrical period.
module dec3f #(
    parameter int CW      = 16,
    parameter int LOCK    = 6,
    parameter int TIMEOUT = 1000
) (
    input  logic          SE,
    input  logic          RST,
    input  logic          A,
    input  logic          B,
    input  logic          C,
    input  logic          CLR,
    output logic [2:0]    SECTOR,
    output logic          DIR,
    output logic          STEP,
    output logic          VALID,
    output logic          FAULT,
    output logic          ERR,
    output logic [CW-1:0] PERIOD,
    output logic          PSTB
);

    localparam logic [5:0]    LOCK_N    = 6'(LOCK);
    localparam logic [15:0]   TIMEOUT_N = 16'(TIMEOUT);
    localparam logic [CW-1:0] PER_ONE   = CW'(1);

    logic [2:0]    sync_1, sync_2;
    logic [1:0]    fill;
    logic [2:0]    prev_sec;
    logic          prev_valid, dir_known, armed;
    logic [5:0]    run_cnt, run_next;
    logic [15:0]   idle_cnt, idle_next;
    logic [CW-1:0] per_cnt, per_sat;

    logic [2:0] cur_sec, fwd_sec, rev_sec;
    logic       load, step_c, step_fwd, fault_c;
    logic       reversal, entry, timed_out, valid_next, pstb_c;

    function automatic logic [2:0] sector_of(input logic [2:0] abc);
        case (abc)
            3'b100:  sector_of = 3'd1;
            3'b110:  sector_of = 3'd2;
            3'b111:  sector_of = 3'd3;
            3'b011:  sector_of = 3'd4;
            3'b001:  sector_of = 3'd5;
            3'b000:  sector_of = 3'd6;
            default: sector_of = 3'd0;
        endcase
    endfunction

    always_comb begin
        cur_sec  = sector_of(sync_2);
        fwd_sec  = (prev_sec == 3'd6) ? 3'd1 : prev_sec + 3'd1;
        rev_sec  = (prev_sec == 3'd1) ? 3'd6 : prev_sec - 3'd1;
        load     = 1'b0;
        step_c   = 1'b0;
        step_fwd = 1'b0;
        fault_c  = 1'b0;

        // fill gates decoding until the synchroniser holds real samples after reset
        if (fill[1]) begin
            if (!prev_valid) begin
                load = (cur_sec != 3'd0);
            end else if (cur_sec != prev_sec) begin
                if (cur_sec == fwd_sec) begin
                    step_c   = 1'b1;
                    step_fwd = 1'b1;
                end else if (cur_sec == rev_sec) begin
                    step_c = 1'b1;
                end else begin
                    fault_c = 1'b1;
                end
            end
        end

        reversal  = step_c && dir_known && (step_fwd != DIR);
        entry     = step_c && (cur_sec == 3'd1);
        pstb_c    = entry && armed && !reversal;
        per_sat   = (per_cnt == '1) ? per_cnt : per_cnt + PER_ONE;
        idle_next = step_c ? 16'd0 :
                    ((idle_cnt >= TIMEOUT_N) ? idle_cnt : idle_cnt + 16'd1);
        timed_out = (idle_next >= TIMEOUT_N);

        if (fault_c || timed_out) begin
            run_next = 6'd0;
        end else if (step_c) begin
            run_next = reversal ? 6'd1 :
                       ((run_cnt >= LOCK_N) ? LOCK_N : run_cnt + 6'd1);
        end else begin
            run_next = run_cnt;
        end

        if (fault_c || timed_out || reversal) begin
            valid_next = 1'b0;
        end else if (step_c) begin
            valid_next = (run_next == LOCK_N);
        end else begin
            valid_next = VALID;
        end
    end

    always_ff @(posedge SE or posedge RST) begin
        if (RST) begin
            sync_1     <= '0;
            sync_2     <= '0;
            fill       <= '0;
            prev_sec   <= '0;
            prev_valid <= 1'b0;
            dir_known  <= 1'b0;
            armed      <= 1'b0;
            run_cnt    <= '0;
            idle_cnt   <= '0;
            per_cnt    <= '0;
            SECTOR     <= '0;
            DIR        <= 1'b0;
            STEP       <= 1'b0;
            VALID      <= 1'b0;
            FAULT      <= 1'b0;
            ERR        <= 1'b0;
            PERIOD     <= '0;
            PSTB       <= 1'b0;
        end else begin
            sync_1   <= {A, B, C};
            sync_2   <= sync_1;
            fill     <= {fill[0], 1'b1};
            STEP     <= step_c;
            FAULT    <= fault_c;
            PSTB     <= pstb_c;
            run_cnt  <= run_next;
            VALID    <= valid_next;
            idle_cnt <= idle_next;
            per_cnt  <= entry ? '0 : per_sat;

            if (load || step_c) begin
                SECTOR     <= cur_sec;
                prev_sec   <= cur_sec;
                prev_valid <= 1'b1;
            end
            if (step_c) begin
                DIR       <= step_fwd;
                dir_known <= 1'b1;
            end
            // a fault forgets all decoding context; DIR keeps its last value
            if (fault_c) begin
                SECTOR     <= 3'd0;
                prev_sec   <= 3'd0;
                prev_valid <= 1'b0;
                dir_known  <= 1'b0;
            end

            if (pstb_c) begin
                PERIOD <= per_sat;
            end
            if (fault_c) begin
                armed <= 1'b0;
            end else if (entry) begin
                armed <= 1'b1;
            end else if (reversal) begin
                armed <= 1'b0;
            end

            if (fault_c) begin
                ERR <= 1'b1;
            end else if (CLR) begin
                ERR <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dec3f.sv
// Bench for dec3f: directed scenarios plus a random phase walk, all checked
// cycle by cycle against a cycle-count based reference model.
module tb_dec3f;

    localparam int CW      = 12;
    localparam int LOCK    = 6;
    localparam int TIMEOUT = 20;
    localparam int PMAX    = 4095;

    logic          SE  = 1'b0;
    logic          RST = 1'b1;
    logic          A = 1'b0, B = 1'b0, C = 1'b0, CLR = 1'b0;
    logic [2:0]    SECTOR;
    logic          DIR, STEP, VALID, FAULT, ERR, PSTB;
    logic [CW-1:0] PERIOD;

    int checks = 0;
    int errors = 0;

    dec3f #(.CW(CW), .LOCK(LOCK), .TIMEOUT(TIMEOUT)) dut (
        .SE(SE), .RST(RST), .A(A), .B(B), .C(C), .CLR(CLR),
        .SECTOR(SECTOR), .DIR(DIR), .STEP(STEP), .VALID(VALID),
        .FAULT(FAULT), .ERR(ERR), .PERIOD(PERIOD), .PSTB(PSTB)
    );

    always #5 SE = ~SE;

    // sector per {A,B,C} code (0 = illegal) and code per sector 1..6
    int sec_lut[8]  = '{6, 5, 0, 4, 1, 0, 2, 3};
    int code_lut[7] = '{0, 4, 6, 7, 3, 1, 0};

    // reference model state; times are absolute edge numbers
    int   n = 0, last_step = 0, entry_cyc = 0, fill_cnt = 0;
    int   run = 0, prev_sec = 0, m_sector = 0, m_period = 0;
    bit   prev_known, dir_known, armed;
    bit   m_dir, m_step, m_valid, m_fault, m_err, m_pstb;
    logic [2:0] hist1, hist2;
    int   s = 1;

    task automatic model_reset();
        last_step = n; entry_cyc = n; fill_cnt = 0;
        run = 0; prev_sec = 0; m_sector = 0; m_period = 0;
        prev_known = 0; dir_known = 0; armed = 0;
        m_dir = 0; m_step = 0; m_valid = 0; m_fault = 0; m_err = 0; m_pstb = 0;
        hist1 = 3'b000; hist2 = 3'b000;
    endtask

    task automatic model_update();
        logic [2:0] use_code;
        bit usable, fault, step, fwd, rev;
        int sec, d;
        n++;
        if (RST) begin
            model_reset();
            return;
        end
        use_code = hist2;
        usable   = (fill_cnt >= 2);
        hist2    = hist1;
        hist1    = {A, B, C};
        if (fill_cnt < 2) fill_cnt++;
        m_step = 0; m_fault = 0; m_pstb = 0; fault = 0; step = 0; fwd = 0;
        if (usable) begin
            sec = sec_lut[use_code];
            if (!prev_known) begin
                if (sec != 0) begin
                    m_sector = sec; prev_sec = sec; prev_known = 1;
                end
            end else if (sec == 0) begin
                fault = 1;
            end else begin
                d = (sec - prev_sec + 6) % 6;
                if (d == 1 || d == 5) begin
                    step = 1; fwd = (d == 1);
                end else if (d != 0) begin
                    fault = 1;
                end
            end
        end
        if (fault) begin
            m_fault = 1; m_err = 1; m_sector = 0; m_valid = 0; run = 0;
            prev_known = 0; prev_sec = 0; armed = 0; dir_known = 0;
        end else if (CLR) begin
            m_err = 0;
        end
        if (step) begin
            rev = dir_known && (fwd != m_dir);
            m_step = 1; m_sector = sec; prev_sec = sec; m_dir = fwd;
            dir_known = 1; last_step = n;
            run = rev ? 1 : ((run < LOCK) ? run + 1 : LOCK);
            m_valid = !rev && (run == LOCK);
            if (sec == 1) begin
                if (armed && !rev) begin
                    m_period = ((n - entry_cyc) > PMAX) ? PMAX : (n - entry_cyc);
                    m_pstb = 1;
                end
                entry_cyc = n; armed = 1;
            end else if (rev) begin
                armed = 0;
            end
        end else if (!fault && (n - last_step) >= TIMEOUT) begin
            run = 0; m_valid = 0;
        end
    endtask

    task automatic run_cycle();
        @(posedge SE);
        model_update();
        @(negedge SE);
    endtask

    task automatic set_sector(input int sec);
        {A, B, C} = 3'(code_lut[sec]);
    endtask

    function automatic logic [20:0] dut_bus();
        return {SECTOR, DIR, STEP, VALID, FAULT, ERR, PERIOD, PSTB};
    endfunction

    function automatic logic [20:0] model_bus();
        return {3'(m_sector), m_dir, m_step, m_valid, m_fault, m_err, 12'(m_period), m_pstb};
    endfunction

    task automatic test_reset();
        {A, B, C} = 3'b100; CLR = 0; RST = 1;
        model_reset();
        repeat (2) run_cycle();
        checks++;
        if (dut_bus() !== 21'd0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", dut_bus());
        end
        RST = 0;
        repeat (2) run_cycle();
        checks++;
        if (SECTOR !== 3'd0) begin
            errors++; $display("[TB] FAIL sector_before_fill: got %0d expected 0", SECTOR);
        end
        run_cycle();
        checks++;
        if ({SECTOR, STEP, FAULT, VALID, ERR} !== 7'b001_0000) begin
            errors++; $display("[TB] FAIL first_load: got %b expected 0010000",
                               {SECTOR, STEP, FAULT, VALID, ERR});
        end
        checks++;
        if (dut_bus() !== model_bus()) begin
            errors++; $display("[TB] FAIL first_load_model: got %h expected %h", dut_bus(), model_bus());
        end
        s = 1;
    endtask

    task automatic test_forward();
        int steps = 0;
        for (int i = 0; i < 12; i++) begin
            s = (s == 6) ? 1 : s + 1;
            set_sector(s);
            repeat (4) begin
                run_cycle();
                checks++;
                if (dut_bus() !== model_bus()) begin
                    errors++; $display("[TB] FAIL fwd_cycle: got %h expected %h", dut_bus(), model_bus());
                end
                if (m_step) begin
                    steps++;
                    if (steps == 5 || steps == 6) begin
                        checks++;
                        if (VALID !== (steps == 6)) begin
                            errors++; $display("[TB] FAIL lock_on_6th_step: step %0d got %b", steps, VALID);
                        end
                    end
                    if (steps == 12) begin
                        checks++;
                        if (PSTB !== 1'b1 || PERIOD !== 12'd24) begin
                            errors++; $display("[TB] FAIL period_24: got pstb=%b period=%0d expected 1/24", PSTB, PERIOD);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reverse();
        int seq[8] = '{2, 3, 2, 1, 6, 5, 4, 3};
        int rsteps = 0;
        foreach (seq[i]) begin
            s = seq[i];
            set_sector(s);
            repeat (4) begin
                run_cycle();
                checks++;
                if (dut_bus() !== model_bus()) begin
                    errors++; $display("[TB] FAIL rev_cycle: got %h expected %h", dut_bus(), model_bus());
                end
                if (m_step && !m_dir) begin
                    rsteps++;
                    if (rsteps == 1) begin
                        checks++;
                        if (DIR !== 1'b0 || VALID !== 1'b0) begin
                            errors++; $display("[TB] FAIL reversal: got dir=%b valid=%b expected 0/0", DIR, VALID);
                        end
                    end
                    if (SECTOR == 3'd1) begin
                        checks++;
                        if (PSTB !== 1'b0) begin
                            errors++; $display("[TB] FAIL no_pstb_after_reversal: got %b expected 0", PSTB);
                        end
                    end
                    if (rsteps == 5 || rsteps == 6) begin
                        checks++;
                        if (VALID !== (rsteps == 6)) begin
                            errors++; $display("[TB] FAIL relock: step %0d got %b", rsteps, VALID);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_fault();
        int nf = 0;
        {A, B, C} = 3'b101;
        repeat (4) begin
            run_cycle();
            checks++;
            if (dut_bus() !== model_bus()) begin
                errors++; $display("[TB] FAIL illegal_cycle: got %h expected %h", dut_bus(), model_bus());
            end
            if (FAULT) begin
                nf++; checks++;
                if (SECTOR !== 3'd0 || ERR !== 1'b1) begin
                    errors++; $display("[TB] FAIL illegal_effect: got sector=%0d err=%b expected 0/1", SECTOR, ERR);
                end
            end
        end
        checks++;
        if (nf != 1) begin
            errors++; $display("[TB] FAIL illegal_pulse: got %0d pulses expected 1", nf);
        end
        s = 1; set_sector(s);
        repeat (4) begin
            run_cycle();
            checks++;
            if (dut_bus() !== model_bus()) begin
                errors++; $display("[TB] FAIL reload_cycle: got %h expected %h", dut_bus(), model_bus());
            end
        end
        checks++;
        if (SECTOR !== 3'd1 || ERR !== 1'b1) begin
            errors++; $display("[TB] FAIL reload_after_illegal: got sector=%0d err=%b expected 1/1", SECTOR, ERR);
        end
        CLR = 1; run_cycle(); CLR = 0;
        checks++;
        if (ERR !== 1'b0) begin
            errors++; $display("[TB] FAIL clr_drops_err: got %b expected 0", ERR);
        end
        s = 2; set_sector(s);
        repeat (4) run_cycle();
        CLR = 1; s = 4; set_sector(s); nf = 0;
        repeat (4) begin
            run_cycle();
            checks++;
            if (dut_bus() !== model_bus()) begin
                errors++; $display("[TB] FAIL skip_cycle: got %h expected %h", dut_bus(), model_bus());
            end
            if (FAULT) begin
                nf++; checks++;
                if (ERR !== 1'b1 || SECTOR !== 3'd0) begin
                    errors++; $display("[TB] FAIL fault_beats_clr: got err=%b sector=%0d expected 1/0", ERR, SECTOR);
                end
            end
        end
        checks++;
        if (nf != 1) begin
            errors++; $display("[TB] FAIL skip_pulse: got %0d pulses expected 1", nf);
        end
        checks++;
        if (SECTOR !== 3'd4 || STEP !== 1'b0 || ERR !== 1'b0) begin
            errors++; $display("[TB] FAIL reload_after_skip: got sector=%0d step=%b err=%b expected 4/0/0", SECTOR, STEP, ERR);
        end
        CLR = 0;
    endtask

    task automatic test_timeout();
        int since = 0;
        for (int i = 0; i < 7; i++) begin
            s = (s == 6) ? 1 : s + 1;
            set_sector(s);
            repeat (4) begin
                run_cycle();
                checks++;
                if (dut_bus() !== model_bus()) begin
                    errors++; $display("[TB] FAIL lock_cycle: got %h expected %h", dut_bus(), model_bus());
                end
                since = m_step ? 0 : since + 1;
            end
        end
        repeat (40) begin
            run_cycle();
            since++;
            checks++;
            if (dut_bus() !== model_bus()) begin
                errors++; $display("[TB] FAIL idle_cycle: got %h expected %h", dut_bus(), model_bus());
            end
            if (since == 19 || since == 20) begin
                checks++;
                if (VALID !== (since == 19)) begin
                    errors++; $display("[TB] FAIL timeout_edge: %0d cycles after step got valid=%b", since, VALID);
                end
            end
            checks++;
            if ({SECTOR, DIR, FAULT} !== 5'b101_1_0) begin
                errors++; $display("[TB] FAIL hold_after_timeout: got %b expected 10110", {SECTOR, DIR, FAULT});
            end
        end
    endtask

    task automatic test_period_sat();
        int np = 0;
        int seq[2] = '{6, 1};
        foreach (seq[i]) begin
            s = seq[i];
            set_sector(s);
            repeat (5000) begin
                run_cycle();
                checks++;
                if (dut_bus() !== model_bus()) begin
                    errors++; $display("[TB] FAIL slow_cycle: got %h expected %h", dut_bus(), model_bus());
                end
                if (PSTB) begin
                    np++; checks++;
                    if (PERIOD !== 12'd4095) begin
                        errors++; $display("[TB] FAIL period_sat: got %0d expected 4095", PERIOD);
                    end
                end
            end
        end
        checks++;
        if (np != 1) begin
            errors++; $display("[TB] FAIL sat_pstb_count: got %0d expected 1", np);
        end
        s = 2; set_sector(s);
        repeat (100) run_cycle();
        #2 RST = 1;
        model_reset();
        #1;
        checks++;
        if (dut_bus() !== 21'd0) begin
            errors++; $display("[TB] FAIL async_reset: got %h expected 0", dut_bus());
        end
        repeat (2) run_cycle();
        RST = 0;
        repeat (4) begin
            run_cycle();
            checks++;
            if (dut_bus() !== model_bus()) begin
                errors++; $display("[TB] FAIL refill_cycle: got %h expected %h", dut_bus(), model_bus());
            end
        end
        checks++;
        if (SECTOR !== 3'd2 || STEP !== 1'b0) begin
            errors++; $display("[TB] FAIL reload_after_reset: got sector=%0d step=%b expected 2/0", SECTOR, STEP);
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        int r, hold;
        while (cyc < 3000) begin
            r = $urandom_range(0, 99);
            if (r < 40)      s = (s == 6) ? 1 : s + 1;
            else if (r < 70) s = (s == 1) ? 6 : s - 1;
            else if (r < 90 && r >= 80) s = ((s - 1 + $urandom_range(2, 4)) % 6) + 1;
            if (r >= 90) {A, B, C} = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b101;
            else         set_sector(s);
            hold = $urandom_range(1, 30);
            repeat (hold) begin
                CLR = ($urandom_range(0, 15) == 0);
                run_cycle();
                cyc++;
                checks++;
                if (dut_bus() !== model_bus()) begin
                    errors++; $display("[TB] FAIL random_cycle %0d: got %h expected %h", n, dut_bus(), model_bus());
                end
            end
        end
        CLR = 0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_fault();
        test_timeout();
        test_period_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dec3f.md
Name: dec3f

Overview:
- Three-phase sequence decoder: the receiving end of the team's three-phase Johnson generator.
- Samples the three phase lines (asynchronous to SE), synchronises them and decodes the 6-step sector.
- Reports rotation direction and lock status, flags illegal codes and skipped steps, and measures the electrical period in SE cycles.
- Sits between the phase lines (or a generator loop-back) and supervisory logic.

Parameters:
CW, 16, width of period counter and PERIOD output
LOCK, 6, consecutive same-direction legal steps required to assert VALID (1..63)
TIMEOUT, 1000, SE cycles without a step before VALID drops (>=2, fits in 16 bits)

Ports:
SE  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
A  input  1  phase A, asynchronous
B  input  1  phase B, asynchronous
C  input  1  phase C, asynchronous
CLR  input  1  synchronous clear of ERR
SECTOR  output  3  current sector 1..6; 0 = unknown
DIR  output  1  1 = forward (A->B->C), 0 = reverse
STEP  output  1  one-cycle pulse per legal step
VALID  output  1  lock indicator
FAULT  output  1  one-cycle pulse on illegal code or skipped step
ERR  output  1  sticky fault flag
PERIOD  output  CW  SE cycles between successive entries into sector 1
PSTB  output  1  one-cycle pulse when PERIOD updates

Behaviour:
- Reset (RST=1, async): synchroniser flops, prev code, all counters and every output = 0; prev-code-valid flag = 0; period not armed.
- Synchroniser: 2 flops per phase. The decode stage uses the second flop; outputs are registered. A stable input change is reflected on outputs at the 3rd SE rising edge after it.
- Code {A,B,C} to sector:
  - 100=1, 110=2, 111=3, 011=4, 001=5, 000=6.
  - 010 and 101 are illegal.
- Each cycle, compare the decoded code with the previous code:
  - First legal code after reset or after a fault: load SECTOR; no STEP, no FAULT; prev-valid=1.
  - Same code: no action.
  - Next sector (6 wraps to 1): STEP=1, DIR=1.
  - Previous sector (1 wraps to 6): STEP=1, DIR=0.
  - Illegal code, or a sector two or more away: FAULT=1, ERR=1, SECTOR=0, VALID=0, run count=0, prev-valid=0, period disarmed.
- Lock:
  - Run counter increments on each STEP in the same direction as the previous step and saturates at LOCK.
  - A reversal sets the run count to 1 and VALID=0.
  - VALID=1 when the run count reaches LOCK.
- Timeout:
  - Idle counter clears on STEP and otherwise increments, saturating.
  - When it reaches TIMEOUT: VALID=0 and run count=0. SECTOR and DIR are held; this is not a fault.
- Period:
  - Free-running counter, saturating at 2^CW-1.
  - On a STEP that enters sector 1 (either direction): if armed, PERIOD = cycles elapsed since the previous such entry (saturated) and PSTB=1. Then the counter restarts and the period is armed.
  - A reversal disarms the period; the entry that caused the reversal only re-arms it.
- ERR: set on FAULT, cleared by CLR. If FAULT and CLR occur in the same cycle, FAULT wins (ERR=1).
- RST asserted mid-operation: immediate return to reset values. Decoding resumes with a first-code load once the synchroniser refills.

Test Plan:
1. Reset, then hold ABC=100 -> after 3 edges SECTOR=1; STEP=0, FAULT=0, VALID=0, ERR=0.
2. Forward sequence 100,110,111,011,001,000,100,…, one code every 4 cycles:
   - STEP pulses every 4 cycles, DIR=1.
   - VALID rises on the 6th step.
   - Second entry into sector 1 gives PSTB with PERIOD=24.
3. After lock, switch to reverse (sector 3 -> 2 -> 1):
   - DIR=0, VALID=0 at the reversal.
   - VALID returns after 6 reverse steps.
   - No PSTB at the first reverse entry into sector 1.
4. Apply 101, then separately jump from 110 to 011:
   - Each gives FAULT for one cycle, ERR=1, SECTOR=0.
   - The next legal code reloads SECTOR with no STEP.
   - CLR then drops ERR.
5. TIMEOUT=20, lock, then freeze inputs -> VALID falls exactly 20 cycles after the last STEP; SECTOR and DIR are held; FAULT=0.
6. Steps of 5000 cycles with CW=12 -> PERIOD saturates at 4095. Also assert RST mid-sequence -> all outputs are 0 in the same cycle.
